// File: rtl/mpsk_symbol_mapper_if.sv
// Bit-stream handshake and I/Q sample bus of the MPSK symbol mapper.
// The master side feeds bits and sample strobes; the slave side returns samples.
interface mpsk_symbol_mapper_if #(
  parameter int W = 16
);
  logic                mode;
  logic                bit_in;
  logic                bit_valid;
  logic                bit_ready;
  logic                sample_en;
  logic signed [W-1:0] out_I;
  logic signed [W-1:0] out_Q;
  logic                out_valid;
  logic                sym_start;
  logic                underflow;

  modport master (
    output mode, bit_in, bit_valid, sample_en,
    input  bit_ready, out_I, out_Q, out_valid, sym_start, underflow
  );

  modport slave (
    input  mode, bit_in, bit_valid, sample_en,
    output bit_ready, out_I, out_Q, out_valid, sym_start, underflow
  );
endinterface

// File: rtl/mpsk_symbol_mapper.sv
// Groups a serial bit stream into BPSK / Gray QPSK symbols and emits signed I/Q
// samples with a zero-order hold of SPS samples, paced by sample_en.
module mpsk_symbol_mapper #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int SPS       = 8,
  parameter int AMP       = 11585
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpsk_symbol_mapper_if.slave  bus
);
  localparam int W    = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int PH_W = (SPS > 1) ? $clog2(SPS) : 1;

  localparam logic signed [W-1:0] POS_AMP = W'(AMP);
  localparam logic signed [W-1:0] NEG_AMP = W'(-AMP);
  localparam logic [PH_W-1:0]     PH_LAST = PH_W'(SPS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } coll_state_t;

  coll_state_t         coll_state_reg;
  logic                half_bit_reg;
  logic                pend_full_reg;
  logic signed [W-1:0] pend_i_reg;
  logic signed [W-1:0] pend_q_reg;

  logic [PH_W-1:0]     ph_reg;
  logic signed [W-1:0] out_i_reg;
  logic signed [W-1:0] out_q_reg;
  logic                out_valid_reg;
  logic                sym_start_reg;
  logic                underflow_reg;

  logic bit_ready;
  logic xfer;
  logic load;

  function automatic logic signed [W-1:0] map_bit(input logic b);
    return b ? NEG_AMP : POS_AMP;
  endfunction

  assign bit_ready = !pend_full_reg && rst_n;
  assign xfer      = bus.bit_valid && bit_ready;
  // The pending symbol moves to the output only at a symbol boundary strobe.
  assign load      = bus.sample_en && (ph_reg == '0) && pend_full_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_state_reg <= EMPTY;
      half_bit_reg   <= 1'b0;
      pend_full_reg  <= 1'b0;
      pend_i_reg     <= '0;
      pend_q_reg     <= '0;
    end else begin
      if (xfer) begin
        case (coll_state_reg)
          EMPTY: begin
            if (bus.mode) begin
              pend_i_reg    <= map_bit(bus.bit_in);
              pend_q_reg    <= '0;
              pend_full_reg <= 1'b1;
            end else begin
              half_bit_reg   <= bus.bit_in;
              coll_state_reg <= HALF;
            end
          end
          HALF: begin
            pend_i_reg     <= map_bit(half_bit_reg);
            pend_q_reg     <= map_bit(bus.bit_in);
            pend_full_reg  <= 1'b1;
            coll_state_reg <= EMPTY;
          end
          default: coll_state_reg <= EMPTY;
        endcase
      end
      // Placed last so a same-cycle clear takes priority over a set.
      if (load) begin
        pend_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_reg        <= '0;
      out_i_reg     <= '0;
      out_q_reg     <= '0;
      out_valid_reg <= 1'b0;
      sym_start_reg <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      sym_start_reg <= 1'b0;
      underflow_reg <= 1'b0;
      if (bus.sample_en) begin
        out_valid_reg <= 1'b1;
        ph_reg        <= (ph_reg == PH_LAST) ? '0 : ph_reg + 1'b1;
        if (ph_reg == '0) begin
          if (pend_full_reg) begin
            out_i_reg     <= pend_i_reg;
            out_q_reg     <= pend_q_reg;
            sym_start_reg <= 1'b1;
          end else begin
            out_i_reg     <= '0;
            out_q_reg     <= '0;
            underflow_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.bit_ready = bit_ready;
  assign bus.out_I     = out_i_reg;
  assign bus.out_Q     = out_q_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sym_start = sym_start_reg;
  assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_mpsk_symbol_mapper.sv
// Randomized bench for mpsk_symbol_mapper: captured samples are compared with a
// reference built from the bit list (symbol k occupies samples k*SPS .. k*SPS+SPS-1).
module tb_mpsk_symbol_mapper;
  localparam int SPS = 8;
  localparam int AMP = 11585;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpsk_symbol_mapper_if #(.W(W)) bus();

  mpsk_symbol_mapper #(
    .SYM_WIDTH(1), .INT_WIDTH(1), .DEC_WIDTH(14), .SPS(SPS), .AMP(AMP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit capture = 1'b0;
  int cap_i[$], cap_q[$], exp_i[$], exp_q[$];
  bit cap_ss[$], cap_uf[$], exp_ss[$], exp_uf[$];

  always @(negedge clk) begin
    if (capture && bus.out_valid === 1'b1) begin
      cap_i.push_back(int'($signed(bus.out_I)));
      cap_q.push_back(int'($signed(bus.out_Q)));
      cap_ss.push_back(bus.sym_start);
      cap_uf.push_back(bus.underflow);
    end
  end

  function automatic int amp_of(input bit b);
    return b ? -AMP : AMP;
  endfunction

  // Reference: symbols in bit order, each held SPS samples, then idle symbols.
  function automatic void build_ref(input bit m, input bit bits[$], input int nstr);
    int step = m ? 1 : 2;
    int nsym = bits.size() / step;
    exp_i.delete(); exp_q.delete(); exp_ss.delete(); exp_uf.delete();
    for (int n = 0; n < nstr; n++) begin
      int k = n / SPS;
      if (k < nsym) begin
        exp_i.push_back(amp_of(bits[k*step]));
        exp_q.push_back(m ? 0 : amp_of(bits[k*step+1]));
        exp_ss.push_back(n % SPS == 0);
        exp_uf.push_back(1'b0);
      end else begin
        exp_i.push_back(0);
        exp_q.push_back(0);
        exp_ss.push_back(1'b0);
        exp_uf.push_back(n % SPS == 0);
      end
    end
  endfunction

  // Called and returns at a falling edge; leaves bit_valid high.
  task automatic feed_bit(input bit b, input bit m);
    int waited = 0;
    bus.bit_in = b;
    bus.mode = m;
    bus.bit_valid = 1'b1;
    while (bus.bit_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: bit_ready=%b, required 1 within 300 cycles", bus.bit_ready);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sample_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_stream(input bit m, input bit bits[$], input int spacing, input int nstr);
    int step = m ? 1 : 2;
    int idx = 0;
    cap_i.delete(); cap_q.delete(); cap_ss.delete(); cap_uf.delete();
    capture = 1'b1;
    if (bits.size() >= step) begin
      for (int j = 0; j < step; j++) feed_bit(bits[j], (j == 0) ? m : bit'($urandom));
      idx = step;
    end
    bus.bit_valid = 1'b0;
    fork
      begin
        while (idx + step <= bits.size()) begin
          for (int j = 0; j < step; j++) feed_bit(bits[idx+j], (j == 0) ? m : bit'($urandom));
          idx += step;
        end
        bus.bit_valid = 1'b0;
      end
      begin
        for (int i = 0; i < nstr; i++) begin
          bus.sample_en = 1'b1;
          @(negedge clk);
          bus.sample_en = 1'b0;
          repeat (spacing - 1) @(negedge clk);
        end
      end
    join
    @(negedge clk);
    @(posedge clk);
    capture = 1'b0;
    @(negedge clk);
    build_ref(m, bits, nstr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_I !== '0) begin n_fail++; $display("FAIL reset_out_I: got %0d, required 0", bus.out_I); end
    n_checks++; if (bus.out_Q !== '0) begin n_fail++; $display("FAIL reset_out_Q: got %0d, required 0", bus.out_Q); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    n_checks++; if (bus.sym_start !== 1'b0) begin n_fail++; $display("FAIL reset_sym_start: got %b, required 0", bus.sym_start); end
    n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b, required 0", bus.underflow); end
    n_checks++; if (bus.bit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_bit_ready: got %b, required 0", bus.bit_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.bit_ready !== 1'b1) begin n_fail++; $display("FAIL release_bit_ready: got %b, required 1", bus.bit_ready); end
    $display("test_reset done");
  endtask

  task automatic test_first_symbol();
    bit q[$];
    q = {1'b0, 1'b1};
    apply_reset();
    run_stream(1'b0, q, 4, 16);
    n_checks++; if (cap_i.size() != 16) begin n_fail++; $display("FAIL first_count: got %0d samples, required 16", cap_i.size()); end
    if (cap_i.size() > 0) begin
      n_checks++;
      if (cap_i[0] !== 11585 || cap_q[0] !== -11585 || cap_ss[0] !== 1'b1) begin
        n_fail++; $display("FAIL first_sample: got I=%0d Q=%0d ss=%0b, required I=11585 Q=-11585 ss=1", cap_i[0], cap_q[0], cap_ss[0]);
      end
    end
    for (int n = 0; n < cap_i.size() && n < 16; n++) begin
      n_checks++;
      if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
        n_fail++; $display("FAIL first[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
      end
    end
    $display("test_first_symbol done: %0d samples", cap_i.size());
  endtask

  task automatic test_gray_sweep();
    bit q[$];
    q = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    run_stream(1'b0, q, 3, 40);
    n_checks++; if (cap_i.size() != 40) begin n_fail++; $display("FAIL gray_count: got %0d samples, required 40", cap_i.size()); end
    for (int n = 0; n < cap_i.size() && n < 40; n++) begin
      n_checks++;
      if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
        n_fail++; $display("FAIL gray[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
      end
    end
    $display("test_gray_sweep done: %0d samples", cap_i.size());
  endtask

  task automatic test_bpsk();
    bit q[$];
    apply_reset();
    feed_bit(1'b1, 1'b1);
    bus.bit_valid = 1'b0;
    n_checks++; if (bus.bit_ready !== 1'b0) begin n_fail++; $display("FAIL bpsk_ready_drop: got %b, required 0", bus.bit_ready); end
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    n_checks++; if (bus.bit_ready !== 1'b1) begin n_fail++; $display("FAIL bpsk_ready_recover: got %b, required 1", bus.bit_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.sym_start !== 1'b1 || int'($signed(bus.out_I)) !== -AMP || bus.out_Q !== '0) begin
      n_fail++; $display("FAIL bpsk_load: got v=%b ss=%b I=%0d Q=%0d, required v=1 ss=1 I=%0d Q=0", bus.out_valid, bus.sym_start, $signed(bus.out_I), $signed(bus.out_Q), -AMP);
    end
    feed_bit(1'b0, 1'b1);
    bus.bit_valid = 1'b0;
    n_checks++; if (bus.bit_ready !== 1'b0) begin n_fail++; $display("FAIL bpsk_ready_drop2: got %b, required 0", bus.bit_ready); end

    apply_reset();
    q = {1'b1, 1'b0};
    for (int i = 0; i < 6; i++) q.push_back(bit'($urandom));
    run_stream(1'b1, q, int'($urandom_range(3, 5)), 72);
    n_checks++; if (cap_i.size() != 72) begin n_fail++; $display("FAIL bpsk_count: got %0d samples, required 72", cap_i.size()); end
    for (int n = 0; n < cap_i.size() && n < 72; n++) begin
      n_checks++;
      if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
        n_fail++; $display("FAIL bpsk[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
      end
    end
    $display("test_bpsk done: %0d samples", cap_i.size());
  endtask

  task automatic test_underflow();
    bit q[$];
    q.delete();
    apply_reset();
    run_stream(1'b0, q, 2, 16);
    n_checks++; if (cap_i.size() != 16) begin n_fail++; $display("FAIL idle_count: got %0d samples, required 16", cap_i.size()); end
    for (int n = 0; n < cap_i.size() && n < 16; n++) begin
      n_checks++;
      if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
        n_fail++; $display("FAIL idle[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
      end
    end
    $display("test_underflow done: %0d samples", cap_i.size());
  endtask

  task automatic test_back_to_back();
    bit q[$];
    for (int pass = 0; pass < 2; pass++) begin
      bit m = (pass == 1);
      int nsym;
      q.delete();
      for (int i = 0; i < 16; i++) q.push_back((pass == 0) ? bit'(i % 2) : bit'($urandom));
      nsym = m ? 16 : 8;
      apply_reset();
      run_stream(m, q, 1, (nsym + 1) * SPS);
      n_checks++; if (cap_i.size() != (nsym + 1) * SPS) begin n_fail++; $display("FAIL b2b_count: got %0d samples, required %0d", cap_i.size(), (nsym + 1) * SPS); end
      for (int n = 0; n < cap_i.size() && n < (nsym + 1) * SPS; n++) begin
        n_checks++;
        if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
          n_fail++; $display("FAIL b2b[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
        end
      end
      $display("test_back_to_back pass %0d done: mode=%0b %0d samples", pass, m, cap_i.size());
    end
  endtask

  task automatic test_random();
    bit q[$];
    for (int it = 0; it < 4; it++) begin
      bit m = bit'($urandom);
      int nbits = int'($urandom_range(2, 6)) * 2;
      int sp = int'($urandom_range(1, 5));
      int nstr;
      q.delete();
      for (int i = 0; i < nbits; i++) q.push_back(bit'($urandom));
      nstr = ((m ? nbits : nbits / 2) + 1) * SPS;
      apply_reset();
      run_stream(m, q, sp, nstr);
      n_checks++; if (cap_i.size() != nstr) begin n_fail++; $display("FAIL rand_count: got %0d samples, required %0d", cap_i.size(), nstr); end
      for (int n = 0; n < cap_i.size() && n < nstr; n++) begin
        n_checks++;
        if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
          n_fail++; $display("FAIL rand%0d[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", it, n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
        end
      end
      $display("test_random %0d done: mode=%0b spacing=%0d %0d samples", it, m, sp, cap_i.size());
    end
  endtask

  task automatic test_reset_mid();
    bit q[$];
    apply_reset();
    feed_bit(1'b0, 1'b0);
    feed_bit(1'b0, 1'b0);
    bus.bit_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_en = 1'b1;
      @(negedge clk);
      bus.sample_en = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (int'($signed(bus.out_I)) !== AMP || int'($signed(bus.out_Q)) !== AMP) begin
      n_fail++; $display("FAIL mid_held: got I=%0d Q=%0d, required I=%0d Q=%0d", $signed(bus.out_I), $signed(bus.out_Q), AMP, AMP);
    end
    feed_bit(1'b0, 1'b0);
    bus.bit_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_I !== '0 || bus.out_Q !== '0 || bus.out_valid !== 1'b0 || bus.sym_start !== 1'b0 || bus.underflow !== 1'b0 || bus.bit_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got I=%0d Q=%0d v=%b ss=%b uf=%b rdy=%b, required all 0", $signed(bus.out_I), $signed(bus.out_Q), bus.out_valid, bus.sym_start, bus.underflow, bus.bit_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    q = {1'b1, 1'b1};
    run_stream(1'b0, q, 2, 16);
    n_checks++; if (cap_i.size() != 16) begin n_fail++; $display("FAIL mid_count: got %0d samples, required 16", cap_i.size()); end
    for (int n = 0; n < cap_i.size() && n < 16; n++) begin
      n_checks++;
      if (cap_i[n] !== exp_i[n] || cap_q[n] !== exp_q[n] || cap_ss[n] !== exp_ss[n] || cap_uf[n] !== exp_uf[n]) begin
        n_fail++; $display("FAIL mid[%0d]: got I=%0d Q=%0d ss=%0b uf=%0b, required I=%0d Q=%0d ss=%0b uf=%0b", n, cap_i[n], cap_q[n], cap_ss[n], cap_uf[n], exp_i[n], exp_q[n], exp_ss[n], exp_uf[n]);
      end
    end
    $display("test_reset_mid done: %0d samples", cap_i.size());
  endtask

  initial begin
    bus.mode = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sample_en = 1'b0;
    test_reset();
    test_first_symbol();
    test_gray_sweep();
    test_bpsk();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
